// File: rtl/csa_resolve_22_pkg.sv
// csa_resolve_22_pkg
// Shared widths for the carry-save resolver family.
//   CSA_W  : width of each redundant (carry/sum) input vector
//   CSA_LO : width of the low-half adder in the first pipeline stage
//   CSA_OW : width of the resolved binary result (W+2 bits holds 3*2^W-3)
package csa_resolve_22_pkg;

  localparam int CSA_W  = 22;
  localparam int CSA_LO = 12;
  localparam int CSA_OW = CSA_W + 2;

endpackage

// File: rtl/csa_resolve_22.sv
// csa_resolve_22
// Two-stage pipelined resolver that turns a carry-save pair (in_s, in_c)
// into the binary value in_s + (in_c << 1). Stage 1 adds the low LO bits
// and forwards the untouched high bits plus the low-half carry; stage 2
// adds the high halves and assembles the result. Valid/ready handshake on
// both sides, one result per cycle, two-cycle latency when unstalled.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   reset     : asynchronous active-high reset, clears all state
//   in_valid  : upstream carry-save pair present
//   in_ready  : pair is accepted this cycle (combinational from state/out_ready)
//   in_c      : carry vector, bit i has weight 2^(i+1)
//   in_s      : sum vector, bit i has weight 2^i
//   out_valid : out_sum holds a resolved result
//   out_ready : downstream consumes out_sum this cycle
//   out_sum   : resolved binary value, W+2 bits
module csa_resolve_22
  import csa_resolve_22_pkg::*;
#(
  parameter int W  = CSA_W,
  parameter int LO = CSA_LO
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_c,
  input  logic [W-1:0]   in_s,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W+1:0]   out_sum
);

  localparam int OW  = W + 2;      // result width
  localparam int HW  = W - LO;     // high s bits carried to stage 2
  localparam int CHW = W - LO + 1; // high c bits; in_c[LO-1] already sits at weight 2^LO
  localparam int RHW = OW - LO;    // high part of the result

  // Pipeline state
  logic           v1_reg;
  logic           v2_reg;
  logic [LO-1:0]  lo_sum_reg;
  logic           lo_carry_reg;
  logic [HW-1:0]  s_hi_reg;
  logic [CHW-1:0] c_hi_reg;
  logic [OW-1:0]  out_sum_reg;

  // Handshake / advance control
  logic adv1;
  logic adv2;
  logic load1;
  logic load2;

  // Stage adders
  logic [LO:0]    lo_add;
  logic [RHW-1:0] hi_add;

  // A stage may advance when it is empty or the stage after it moves.
  assign adv2     = !v2_reg || out_ready;
  assign adv1     = !v1_reg || adv2;
  assign in_ready = adv1;

  // Data registers only load when real data moves in, so bubbles never toggle them.
  assign load1 = in_valid && adv1;
  assign load2 = v1_reg && adv2;

  // Low half: in_c is pre-shifted by one, so only in_c[LO-2:0] lands inside it.
  assign lo_add = {1'b0, in_s[LO-1:0]} + {1'b0, in_c[LO-2:0], 1'b0};

  // High half at weight 2^LO; RHW bits cover the worst case with no truncation.
  assign hi_add = RHW'(s_hi_reg) + RHW'(c_hi_reg) + RHW'(lo_carry_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
    end else begin
      if (adv1) v1_reg <= in_valid;
      if (adv2) v2_reg <= v1_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_sum_reg   <= '0;
      lo_carry_reg <= 1'b0;
      s_hi_reg     <= '0;
      c_hi_reg     <= '0;
    end else if (load1) begin
      lo_sum_reg   <= lo_add[LO-1:0];
      lo_carry_reg <= lo_add[LO];
      s_hi_reg     <= in_s[W-1:LO];
      c_hi_reg     <= in_c[W-1:LO-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_sum_reg <= '0;
    end else if (load2) begin
      out_sum_reg <= {hi_add, lo_sum_reg};
    end
  end

  assign out_valid = v2_reg;
  assign out_sum   = out_sum_reg;

endmodule

// File: tb/tb_csa_resolve_22.sv
// tb_csa_resolve_22
// Self-checking bench for csa_resolve_22: directed corner values, back-pressure,
// a 100-pair random stream and reset with data in flight. Expected results
// come from plain integer arithmetic s + 2*c held in a FIFO queue.
module tb_csa_resolve_22;
  import csa_resolve_22_pkg::*;

  localparam int W  = CSA_W;
  localparam int OW = CSA_OW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_c;
  logic [W-1:0]  in_s;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_sum;

  int            vec_count = 0;
  int            err_count = 0;
  logic [OW-1:0] exp_q[$];

  always #5 clk = ~clk;

  csa_resolve_22 dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_c     (in_c),
    .in_s     (in_s),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum)
  );

  // Reference: the integer value of a carry-save pair.
  function automatic logic [OW-1:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
    longint unsigned v;
    v = 64'(s) + 2 * 64'(c);
    return OW'(v);
  endfunction

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_c = '0; in_s = '0;
    tick(); tick();
    vec_count++;
    if (out_valid !== 1'b0 || out_sum !== '0) begin
      err_count++;
      $display("FAIL reset_state: out_valid=%b out_sum=%h, required 0/0", out_valid, out_sum);
    end
    reset = 1'b0;
    #1;
    vec_count++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      err_count++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    $display("reset: out_valid=%b in_ready=%b out_sum=%h", out_valid, in_ready, out_sum);
  endtask

  task automatic test_directed();
    logic [W-1:0]  ds[3];
    logic [W-1:0]  dc[3];
    logic [OW-1:0] e;
    ds[0] = 22'h000001; dc[0] = 22'h000001;
    ds[1] = 22'h3FFFFF; dc[1] = 22'h3FFFFF;
    ds[2] = 22'h000FFF; dc[2] = 22'h000001;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_s = ds[k]; in_c = dc[k]; in_valid = 1'b1;
      e = model(ds[k], dc[k]);
      #1;
      vec_count++;
      if (in_ready !== 1'b1) begin
        err_count++;
        $display("FAIL directed_accept[%0d]: in_ready=%b, required 1", k, in_ready);
      end
      tick();
      in_valid = 1'b0;
      vec_count++;
      if (out_valid !== 1'b0) begin
        err_count++;
        $display("FAIL directed_early[%0d]: out_valid=%b one cycle after accept, required 0", k, out_valid);
      end
      tick();
      vec_count++;
      if (out_valid !== 1'b1 || out_sum !== e) begin
        err_count++;
        $display("FAIL directed_result[%0d]: out_valid=%b out_sum=%h, required 1/%h", k, out_valid, out_sum, e);
      end
      $display("directed s=%h c=%h -> out_sum=%h expected=%h", ds[k], dc[k], out_sum, e);
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]  ps[3];
    logic [W-1:0]  pc[3];
    logic [OW-1:0] held;
    logic [OW-1:0] e;
    for (int k = 0; k < 3; k++) begin ps[k] = rnd(); pc[k] = rnd(); end
    exp_q.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_s = ps[k]; in_c = pc[k]; in_valid = 1'b1;
      #1;
      vec_count++;
      if (in_ready !== 1'b1) begin
        err_count++;
        $display("FAIL bp_accept[%0d]: in_ready=%b, required 1", k, in_ready);
      end
      exp_q.push_back(model(ps[k], pc[k]));
      $display("bp push s=%h c=%h", ps[k], pc[k]);
      tick();
    end
    in_s = ps[2]; in_c = pc[2]; in_valid = 1'b1;
    #1;
    vec_count++;
    if (in_ready !== 1'b0) begin
      err_count++;
      $display("FAIL bp_full: in_ready=%b with both stages full, required 0", in_ready);
    end
    held = out_sum;
    tick();
    vec_count++;
    if (out_valid !== 1'b1 || out_sum !== held || in_ready !== 1'b0) begin
      err_count++;
      $display("FAIL bp_hold: out_valid=%b out_sum=%h in_ready=%b, required 1/%h/0", out_valid, out_sum, in_ready, held);
    end
    // Release: output and input transfer in the same cycle.
    out_ready = 1'b1;
    #1;
    vec_count++;
    if (in_ready !== 1'b1) begin
      err_count++;
      $display("FAIL bp_release: in_ready=%b, required 1", in_ready);
    end
    exp_q.push_back(model(ps[2], pc[2]));
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      vec_count++;
      if (out_valid !== 1'b1 || out_sum !== e) begin
        err_count++;
        $display("FAIL bp_drain[%0d]: out_valid=%b out_sum=%h, required 1/%h", k, out_valid, out_sum, e);
      end
      $display("bp drain[%0d] out_sum=%h expected=%h", k, out_sum, e);
      tick();
      in_valid = 1'b0;
      #1;
    end
    vec_count++;
    if (out_valid !== 1'b0) begin
      err_count++;
      $display("FAIL bp_dup: out_valid=%b after drain, required 0", out_valid);
    end
  endtask

  task automatic test_stream();
    int            n_in  = 0;
    int            n_out = 0;
    int            cyc   = 0;
    logic [W-1:0]  s;
    logic [W-1:0]  c;
    logic [OW-1:0] e;
    exp_q.delete();
    out_ready = 1'b1;
    while (n_out < 100 && cyc < 200) begin
      if (n_in < 100) begin
        s = rnd(); c = rnd();
        in_s = s; in_c = c; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid) begin
        vec_count++;
        if (in_ready !== 1'b1) begin
          err_count++;
          $display("FAIL stream_ready[%0d]: in_ready=%b, required 1", cyc, in_ready);
        end
        exp_q.push_back(model(s, c));
        n_in++;
      end
      if (cyc >= 2 && n_out < 100) begin
        vec_count++;
        if (out_valid !== 1'b1) begin
          err_count++;
          $display("FAIL stream_gap[%0d]: out_valid=%b, required 1", cyc, out_valid);
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          vec_count++;
          err_count++;
          $display("FAIL stream_spurious[%0d]: out_sum=%h with nothing expected, required no output", cyc, out_sum);
        end else begin
          e = exp_q.pop_front();
          vec_count++;
          if (out_sum !== e) begin
            err_count++;
            $display("FAIL stream_data[%0d]: out_sum=%h, required %h", n_out, out_sum, e);
          end
          $display("stream result[%0d] out_sum=%h expected=%h", n_out, out_sum, e);
          n_out++;
        end
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    vec_count++;
    if (n_out != 100) begin
      err_count++;
      $display("FAIL stream_timeout: %0d results seen, required 100", n_out);
    end
  endtask

  task automatic test_reset_inflight();
    logic [W-1:0]  s;
    logic [W-1:0]  c;
    logic [OW-1:0] e;
    logic          seen;
    exp_q.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_s = rnd(); in_c = rnd(); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #1;
    vec_count++;
    if (out_valid !== 1'b1) begin
      err_count++;
      $display("FAIL rst_inflight_pre: out_valid=%b before reset, required 1", out_valid);
    end
    reset = 1'b1;
    #1;
    vec_count++;
    if (out_valid !== 1'b0 || out_sum !== '0) begin
      err_count++;
      $display("FAIL rst_inflight_clear: out_valid=%b out_sum=%h, required 0/0", out_valid, out_sum);
    end
    tick();
    reset = 1'b0;
    #1;
    vec_count++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      err_count++;
      $display("FAIL rst_inflight_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    s = rnd(); c = rnd();
    e = model(s, c);
    in_s = s; in_c = c; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      if (out_valid) begin
        seen = 1'b1;
        vec_count++;
        if (out_sum !== e) begin
          err_count++;
          $display("FAIL rst_inflight_next: out_sum=%h, required %h", out_sum, e);
        end
        $display("post-reset result out_sum=%h expected=%h", out_sum, e);
      end
      tick();
    end
    if (!seen) begin
      vec_count++;
      err_count++;
      $display("FAIL rst_inflight_timeout: out_valid=0 for 6 cycles, required a result");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_stream();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/csa_resolve_22.md
CSA_RESOLVE_22 -- requirements
Module: csa_resolve_22

Interface
REQ-001 SHALL have parameter W, default 22: width of each redundant input vector.
REQ-002 SHALL have parameter LO, default 12: bit width of the low-half adder in stage 1.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: upstream carry-save pair present.
REQ-006 SHALL have port in_ready, output, 1: block accepts the pair this cycle.
REQ-007 SHALL have port in_c, input, W: carry vector from the 3:2 compressor; bit i has weight 2^(i+1).
REQ-008 SHALL have port in_s, input, W: sum vector; bit i has weight 2^i.
REQ-009 SHALL have port out_valid, output, 1: out_sum holds a resolved result.
REQ-010 SHALL have port out_ready, input, 1: downstream consumes out_sum this cycle.
REQ-011 SHALL have port out_sum, output, W+2: binary value in_s + (in_c << 1).

Function
REQ-012 A transfer SHALL occur on in_valid && in_ready (input side) or on out_valid && out_ready (output side).
REQ-013 Stage 1 SHALL compute in_s[LO-1:0] + {in_c[LO-2:0],0} and register LO result bits plus a carry-out, together with in_s[W-1:LO] and in_c[W-1:LO-1].
REQ-014 Stage 2 SHALL add the registered high s bits, the high c bits (aligned at weight 2^LO) and the stage-1 carry, and register out_sum = {high result, low LO bits}.
REQ-015 The result SHALL be exact for all inputs; the maximum is 3*2^W-3, which needs no truncation.
REQ-016 The stage-2 advance SHALL be adv2 = !v2 || out_ready; the stage-1 advance SHALL be adv1 = !v1 || adv2; in_ready SHALL equal adv1 (combinational, no path from in_valid).
REQ-017 Latency SHALL be 2 cycles from input transfer to out_valid when unstalled; throughput SHALL be one result per cycle.
REQ-018 While out_valid && !out_ready, out_sum SHALL be held stable, and no register SHALL change except as needed to fill an empty stage 1.
REQ-019 With both stages full and out_ready low, in_ready SHALL be 0.
REQ-020 Simultaneous input and output transfers SHALL both complete in the same cycle without loss or duplication.
REQ-021 Results SHALL emerge in acceptance order.
REQ-022 A stage SHALL not update its data registers when it is not loading (no toggling on bubbles).

Reset
REQ-023 Asserting reset SHALL immediately clear v1, v2, all data registers and out_sum to 0, giving out_valid=0 and in_ready=1 after deassertion.
REQ-024 Reset during a stall or with data in flight SHALL discard in-flight data; no stale result SHALL appear afterward.

Structure
REQ-025 A shared package SHALL hold W, LO and the derived output width W+2; csa_22 and csa_resolve_22 SHALL both use it.
REQ-026 No sub-module is required; both stage adders SHALL be inline behavioural additions.

Verification
REQ-027 in_c=0x000001, in_s=0x000001 -> out_sum=0x000003, out_valid exactly 2 cycles after acceptance.
REQ-028 in_c=0x3FFFFF, in_s=0x3FFFFF -> out_sum=0xBFFFFD (maximum value, no truncation).
REQ-029 in_s=0x000FFF, in_c=0x000001 -> out_sum=0x001001 (carry crosses the LO split).
REQ-030 Push 3 pairs back-to-back with out_ready=0 -> in_ready falls after 2 accepts; raising out_ready drains all 3 in order, with no gaps or duplicates.
REQ-031 Continuous in_valid and out_ready over 100 random pairs -> one result per cycle, each matching the s+(c<<1) model.
REQ-032 Assert reset with 2 results in flight -> out_valid=0 at once; the next result after reset is the first post-reset input.
